// File: rtl/imu_bias_cal.sv
// Gyro bias calibration: averages 2^CAL_SAMPLES_LOG2 stationary samples, then streams
// bias-corrected saturated gyro plus registered accel with 1-cycle latency.
module imu_bias_cal #(
    parameter int CAL_SAMPLES_LOG2 = 6,
    parameter int MOTION_THR       = 2000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic signed [15:0] accel_x,
    input  logic signed [15:0] accel_y,
    input  logic signed [15:0] accel_z,
    input  logic signed [15:0] gyro_x,
    input  logic signed [15:0] gyro_y,
    input  logic signed [15:0] gyro_z,
    input  logic               recal,
    output logic signed [15:0] accel_x_out,
    output logic signed [15:0] accel_y_out,
    output logic signed [15:0] accel_z_out,
    output logic signed [15:0] gyro_x_out,
    output logic signed [15:0] gyro_y_out,
    output logic signed [15:0] gyro_z_out,
    output logic               out_valid,
    output logic               cal_done,
    output logic signed [15:0] bias_x,
    output logic signed [15:0] bias_y,
    output logic signed [15:0] bias_z
);
    localparam int AW = 16 + CAL_SAMPLES_LOG2;
    localparam int CW = CAL_SAMPLES_LOG2 + 1;
    localparam logic [0:0]    S_CAL    = 1'b0;
    localparam logic [0:0]    S_RUN    = 1'b1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << CAL_SAMPLES_LOG2) - 1);
    localparam logic [16:0]   THR      = 17'(MOTION_THR);

    function automatic logic [16:0] abs17(input logic [15:0] v);
        logic [16:0] e;
        e = {v[15], v};
        return v[15] ? (~e + 17'd1) : e;
    endfunction

    function automatic logic [15:0] sat_sub(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] d;
        d = {a[15], a} - {b[15], b};
        if (d[16] != d[15]) return d[16] ? 16'h8000 : 16'h7fff;
        return d[15:0];
    endfunction

    logic [0:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     acc_x_q, acc_x_d, acc_y_q, acc_y_d, acc_z_q, acc_z_d;
    logic [AW-1:0]     sum_x, sum_y, sum_z;
    logic [15:0]       bias_x_q, bias_x_d, bias_y_q, bias_y_d, bias_z_q, bias_z_d;
    logic [15:0]       ax_q, ax_d, ay_q, ay_d, az_q, az_d;
    logic [15:0]       gx_q, gx_d, gy_q, gy_d, gz_q, gz_d;
    logic              out_valid_q, out_valid_d, cal_done_q, cal_done_d;
    logic              motion;

    always_comb begin
        sum_x  = acc_x_q + {{CAL_SAMPLES_LOG2{gyro_x[15]}}, gyro_x};
        sum_y  = acc_y_q + {{CAL_SAMPLES_LOG2{gyro_y[15]}}, gyro_y};
        sum_z  = acc_z_q + {{CAL_SAMPLES_LOG2{gyro_z[15]}}, gyro_z};
        motion = (abs17(gyro_x) > THR) || (abs17(gyro_y) > THR) || (abs17(gyro_z) > THR);

        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_x_d     = acc_x_q;
        acc_y_d     = acc_y_q;
        acc_z_d     = acc_z_q;
        bias_x_d    = bias_x_q;
        bias_y_d    = bias_y_q;
        bias_z_d    = bias_z_q;
        cal_done_d  = cal_done_q;
        out_valid_d = 1'b0;
        ax_d = ax_q;  ay_d = ay_q;  az_d = az_q;
        gx_d = gx_q;  gy_d = gy_q;  gz_d = gz_q;

        if (recal) begin
            state_d    = S_CAL;
            cal_done_d = 1'b0;
            cnt_d      = '0;
            acc_x_d    = '0;
            acc_y_d    = '0;
            acc_z_d    = '0;
        end else if (in_valid) begin
            if (state_q == S_CAL) begin
                if (motion) begin
                    cnt_d   = '0;
                    acc_x_d = '0;
                    acc_y_d = '0;
                    acc_z_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Taking the 16 bits above the fraction is an arithmetic shift (floor).
                    bias_x_d   = sum_x[CAL_SAMPLES_LOG2 +: 16];
                    bias_y_d   = sum_y[CAL_SAMPLES_LOG2 +: 16];
                    bias_z_d   = sum_z[CAL_SAMPLES_LOG2 +: 16];
                    cal_done_d = 1'b1;
                    state_d    = S_RUN;
                    cnt_d      = '0;
                    acc_x_d    = '0;
                    acc_y_d    = '0;
                    acc_z_d    = '0;
                end else begin
                    acc_x_d = sum_x;
                    acc_y_d = sum_y;
                    acc_z_d = sum_z;
                    cnt_d   = cnt_q + 1'b1;
                end
            end else begin
                out_valid_d = 1'b1;
                ax_d = accel_x;
                ay_d = accel_y;
                az_d = accel_z;
                gx_d = sat_sub(gyro_x, bias_x_q);
                gy_d = sat_sub(gyro_y, bias_y_q);
                gz_d = sat_sub(gyro_z, bias_z_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_CAL;
            cnt_q       <= '0;
            acc_x_q     <= '0;
            acc_y_q     <= '0;
            acc_z_q     <= '0;
            bias_x_q    <= '0;
            bias_y_q    <= '0;
            bias_z_q    <= '0;
            cal_done_q  <= 1'b0;
            out_valid_q <= 1'b0;
            ax_q <= '0;  ay_q <= '0;  az_q <= '0;
            gx_q <= '0;  gy_q <= '0;  gz_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_x_q     <= acc_x_d;
            acc_y_q     <= acc_y_d;
            acc_z_q     <= acc_z_d;
            bias_x_q    <= bias_x_d;
            bias_y_q    <= bias_y_d;
            bias_z_q    <= bias_z_d;
            cal_done_q  <= cal_done_d;
            out_valid_q <= out_valid_d;
            ax_q <= ax_d;  ay_q <= ay_d;  az_q <= az_d;
            gx_q <= gx_d;  gy_q <= gy_d;  gz_q <= gz_d;
        end
    end

    assign accel_x_out = ax_q;
    assign accel_y_out = ay_q;
    assign accel_z_out = az_q;
    assign gyro_x_out  = gx_q;
    assign gyro_y_out  = gy_q;
    assign gyro_z_out  = gz_q;
    assign out_valid   = out_valid_q;
    assign cal_done    = cal_done_q;
    assign bias_x      = bias_x_q;
    assign bias_y      = bias_y_q;
    assign bias_z      = bias_z_q;
endmodule

// File: tb/tb_imu_bias_cal.sv
// Directed bench for imu_bias_cal with a 4-sample calibration window.
module tb_imu_bias_cal;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               recal = 1'b0;
    logic signed [15:0] accel_x = '0, accel_y = '0, accel_z = '0;
    logic signed [15:0] gyro_x = '0, gyro_y = '0, gyro_z = '0;
    logic signed [15:0] accel_x_out, accel_y_out, accel_z_out;
    logic signed [15:0] gyro_x_out, gyro_y_out, gyro_z_out;
    logic signed [15:0] bias_x, bias_y, bias_z;
    logic               out_valid, cal_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imu_bias_cal #(.CAL_SAMPLES_LOG2(2), .MOTION_THR(2000)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
        .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
        .recal(recal),
        .accel_x_out(accel_x_out), .accel_y_out(accel_y_out), .accel_z_out(accel_z_out),
        .gyro_x_out(gyro_x_out), .gyro_y_out(gyro_y_out), .gyro_z_out(gyro_z_out),
        .out_valid(out_valid), .cal_done(cal_done),
        .bias_x(bias_x), .bias_y(bias_y), .bias_z(bias_z)
    );

    typedef struct {
        logic               v;
        logic signed [15:0] gx, gy, gz, ax, ay, az;
        logic               eov;
        logic signed [15:0] egx, egy, egz, eax, eay, eaz;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic rc,
                       input logic signed [15:0] gx, gy, gz, ax, ay, az);
        in_valid = v; recal = rc;
        gyro_x = gx; gyro_y = gy; gyro_z = gz;
        accel_x = ax; accel_y = ay; accel_z = az;
        tick();
        in_valid = 1'b0; recal = 1'b0;
    endtask

    task automatic cal(input logic signed [15:0] gx, gy, gz);
        put(1'b1, 1'b0, gx, gy, gz, 16'sd0, 16'sd0, 16'sd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        vecs[0] = '{1'b1, 16'sd100, 16'sd0, 16'sd0, -16'sd500, 16'sd7, 16'sd16384,
                    1'b1, 16'sd87, 16'sd2, 16'sd0, -16'sd500, 16'sd7, 16'sd16384};
        vecs[1] = '{1'b1, 16'sh8000, 16'sh7fff, 16'sh8000, 16'sd1, 16'sd2, 16'sd3,
                    1'b1, 16'sh8000, 16'sh7fff, 16'sh8000, 16'sd1, 16'sd2, 16'sd3};
        vecs[2] = '{1'b1, 16'sh7fff, 16'sh8000, 16'sh7fff, 16'sh8000, 16'sh7fff, 16'sd0,
                    1'b1, 16'sd32754, -16'sd32766, 16'sh7fff, 16'sh8000, 16'sh7fff, 16'sd0};
        vecs[3] = '{1'b0, 16'sd5, 16'sd5, 16'sd5, 16'sd5, 16'sd5, 16'sd5,
                    1'b0, 16'sd32754, -16'sd32766, 16'sh7fff, 16'sh8000, 16'sh7fff, 16'sd0};
        vecs[4] = '{1'b1, 16'sd13, -16'sd2, -16'sd1, 16'sd10, 16'sd20, 16'sd30,
                    1'b1, 16'sd0, 16'sd0, -16'sd1, 16'sd10, 16'sd20, 16'sd30};
        vecs[5] = '{1'b0, 16'sd9, 16'sd9, 16'sd9, 16'sd9, 16'sd9, 16'sd9,
                    1'b0, 16'sd0, 16'sd0, -16'sd1, 16'sd10, 16'sd20, 16'sd30};

        // Reset state.
        idle(3);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_cal_done", cal_done, 0);
        chk("rst_bias_x", bias_x, 0);
        chk("rst_gyro_x_out", gyro_x_out, 0);
        chk("rst_accel_z_out", accel_z_out, 0);
        @(negedge clk) rst_n = 1'b1;

        // Calibration with idle gaps of 0..3 cycles.
        cal(16'sd10, -16'sd1, 16'sd0);
        chk("cal1_ov", out_valid, 0);
        cal(16'sd12, -16'sd2, 16'sd0);
        chk("cal2_ov", out_valid, 0);
        idle(3);
        cal(16'sd14, -16'sd2, 16'sd0);
        chk("cal3_ov", out_valid, 0);
        chk("cal3_done", cal_done, 0);
        idle(1);
        cal(16'sd16, -16'sd2, 16'sd0);
        chk("cal4_ov", out_valid, 0);
        chk("cal4_done", cal_done, 1);
        chk("cal4_bias_x", bias_x, 13);
        chk("cal4_bias_y", bias_y, -2);
        chk("cal4_bias_z", bias_z, 0);

        // Streaming and saturation, back-to-back and with gaps.
        for (int i = 0; i < 6; i++) begin
            put(vecs[i].v, 1'b0, vecs[i].gx, vecs[i].gy, vecs[i].gz,
                vecs[i].ax, vecs[i].ay, vecs[i].az);
            chk($sformatf("vec%0d_ov", i), out_valid, vecs[i].eov);
            chk($sformatf("vec%0d_gx", i), gyro_x_out, vecs[i].egx);
            chk($sformatf("vec%0d_gy", i), gyro_y_out, vecs[i].egy);
            chk($sformatf("vec%0d_gz", i), gyro_z_out, vecs[i].egz);
            chk($sformatf("vec%0d_ax", i), accel_x_out, vecs[i].eax);
            chk($sformatf("vec%0d_ay", i), accel_y_out, vecs[i].eay);
            chk($sformatf("vec%0d_az", i), accel_z_out, vecs[i].eaz);
        end

        // recal wins over a simultaneous sample.
        put(1'b1, 1'b1, 16'sd100, 16'sd0, 16'sd0, 16'sd1, 16'sd1, 16'sd1);
        chk("recal_ov", out_valid, 0);
        chk("recal_done", cal_done, 0);
        chk("recal_bias_x", bias_x, 13);
        chk("recal_bias_y", bias_y, -2);

        // Motion rejection restarts the count and discards earlier samples.
        cal(16'sd500, 16'sd500, 16'sd500);
        idle(1);
        cal(16'sd500, 16'sd500, 16'sd500);
        cal(16'sd0, 16'sd0, 16'sd2500);
        cal(16'sh8000, 16'sd0, 16'sd0);
        cal(16'sd20, 16'sd4, -16'sd3);
        cal(16'sd20, 16'sd4, -16'sd3);
        chk("mot2_done", cal_done, 0);
        cal(16'sd20, 16'sd4, -16'sd3);
        chk("mot3_done", cal_done, 0);
        chk("mot3_bias_x_held", bias_x, 13);
        cal(16'sd24, 16'sd4, -16'sd4);
        chk("mot4_done", cal_done, 1);
        chk("mot4_bias_x", bias_x, 21);
        chk("mot4_bias_y", bias_y, 4);
        chk("mot4_bias_z", bias_z, -4);

        put(1'b1, 1'b0, 16'sd0, 16'sd0, 16'sd0, 16'sd77, 16'sd0, 16'sd0);
        chk("new_ov", out_valid, 1);
        chk("new_gx", gyro_x_out, -21);
        chk("new_gy", gyro_y_out, -4);
        chk("new_gz", gyro_z_out, 4);
        tick();
        chk("new_ov_drop", out_valid, 0);

        // Asynchronous reset mid-stream.
        put(1'b1, 1'b0, 16'sd50, 16'sd50, 16'sd50, 16'sd50, 16'sd50, 16'sd50);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ov", out_valid, 0);
        chk("arst_done", cal_done, 0);
        chk("arst_gx", gyro_x_out, 0);
        chk("arst_ax", accel_x_out, 0);
        chk("arst_bias_x", bias_x, 0);
        @(negedge clk) rst_n = 1'b1;
        cal(16'sd8, 16'sd8, 16'sd8);
        cal(16'sd8, 16'sd8, 16'sd8);
        cal(16'sd8, 16'sd8, 16'sd8);
        chk("post_rst3_done", cal_done, 0);
        cal(16'sd8, 16'sd8, 16'sd8);
        chk("post_rst4_done", cal_done, 1);
        chk("post_rst4_bias_x", bias_x, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
